// File: rtl/cu_pkg.sv
// cu_pkg: opcodes, ALU encodings, FSM states and decode helpers for the control unit
package cu_pkg;
    localparam int OPCODE_W = 3;
    localparam int ALU_OP_W = 2;
    localparam int RETIRE_W = 8;

    localparam logic [OPCODE_W-1:0] OP_ADD   = 3'd0;
    localparam logic [OPCODE_W-1:0] OP_SUB   = 3'd1;
    localparam logic [OPCODE_W-1:0] OP_AND   = 3'd2;
    localparam logic [OPCODE_W-1:0] OP_OR    = 3'd3;
    localparam logic [OPCODE_W-1:0] OP_LOAD  = 3'd4;
    localparam logic [OPCODE_W-1:0] OP_STORE = 3'd5;
    localparam logic [OPCODE_W-1:0] OP_JUMP  = 3'd6;
    localparam logic [OPCODE_W-1:0] OP_HALT  = 3'd7;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 2'b00;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 2'b01;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 2'b10;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_HALT, S_ERROR
    } state_t;

    function automatic logic is_alu(input logic [OPCODE_W-1:0] op);
        return op < OP_LOAD;
    endfunction

    // ALU opcodes map straight onto the ALU encoding; everything else uses ADD
    function automatic logic [ALU_OP_W-1:0] alu_of(input logic [OPCODE_W-1:0] op);
        return is_alu(op) ? op[ALU_OP_W-1:0] : ALU_ADD;
    endfunction
endpackage

// File: rtl/cu_if.sv
// cu_if: instruction/memory inputs and datapath control outputs of the control unit
interface cu_if;
    logic [cu_pkg::OPCODE_W-1:0] opcode;
    logic                        mem_ready;
    logic                        pc_inc;
    logic                        ir_load;
    logic                        pc_load;
    logic                        reg_write;
    logic                        mem_read;
    logic                        mem_write;
    logic [cu_pkg::ALU_OP_W-1:0] alu_op;
    logic                        instr_done;
    logic                        halted;
    logic                        error;
    logic [cu_pkg::RETIRE_W-1:0] retire_count;

    modport master (
        input  opcode, mem_ready,
        output pc_inc, ir_load, pc_load, reg_write, mem_read, mem_write,
               alu_op, instr_done, halted, error, retire_count
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_inc, ir_load, pc_load, reg_write, mem_read, mem_write,
               alu_op, instr_done, halted, error, retire_count
    );
endinterface

// File: rtl/cu_wait_timer.sv
// cu_wait_timer: clearable wait counter flagging the last allowed cycle before timeout
module cu_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

    logic [CW-1:0] cnt_d, cnt_q;

    // clear has priority so every MEM visit starts counting from zero
    always_comb begin
        cnt_d = clr ? '0 : en ? cnt_q + CW'(1) : cnt_q;
    end

    // counter register
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign expired = (TIMEOUT > 0) && (cnt_q == LAST);
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer with memory timeout and retire counter
module multicycle_control_unit
    import cu_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    cu_if.master bus
);
    state_t                state_d, state_q;
    logic [OPCODE_W-1:0]   op_d, op_q;
    logic                  halt_seen_d, halt_seen_q;
    logic [RETIRE_W-1:0]   retire_d, retire_q;
    logic                  timeout;
    logic                  in_mem;
    logic                  done;

    assign in_mem = state_q == S_MEM;

    cu_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (!in_mem),
        .en      (in_mem),
        .expired (timeout)
    );

    // next state, opcode latch, HALT entry tracking and retire counting
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        halt_seen_d = state_q == S_HALT;
        retire_d    = retire_q + RETIRE_W'(done);
        case (state_q)
            S_IDLE:      state_d = S_FETCH;
            S_FETCH:     state_d = S_DECODE;
            S_DECODE: begin
                op_d    = bus.opcode;
                state_d = bus.opcode == OP_HALT ? S_HALT
                        : (bus.opcode == OP_LOAD || bus.opcode == OP_STORE) ? S_MEM
                        : S_EXECUTE;
            end
            S_EXECUTE:   state_d = op_q == OP_JUMP ? S_FETCH : S_WRITEBACK;
            S_MEM:       state_d = bus.mem_ready ? (op_q == OP_LOAD ? S_WRITEBACK : S_FETCH)
                                 : timeout ? S_ERROR : S_MEM;
            S_WRITEBACK: state_d = S_FETCH;
            default:     state_d = state_q;
        endcase
    end

    // state and bookkeeping registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            halt_seen_q <= 1'b0;
            retire_q    <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            halt_seen_q <= halt_seen_d;
            retire_q    <= retire_d;
        end
    end

    // STORE completes in the same cycle memory acknowledges, so its done pulse follows mem_ready
    assign done = state_q == S_WRITEBACK
               || (state_q == S_EXECUTE && op_q == OP_JUMP)
               || (in_mem && op_q == OP_STORE && bus.mem_ready)
               || (state_q == S_HALT && !halt_seen_q);

    assign bus.pc_inc       = state_q == S_FETCH;
    assign bus.ir_load      = state_q == S_FETCH;
    assign bus.pc_load      = state_q == S_EXECUTE && op_q == OP_JUMP;
    assign bus.reg_write    = state_q == S_WRITEBACK;
    assign bus.mem_read     = in_mem && op_q == OP_LOAD;
    assign bus.mem_write    = in_mem && op_q == OP_STORE;
    assign bus.alu_op       = (state_q == S_EXECUTE || state_q == S_WRITEBACK) ? alu_of(op_q) : ALU_ADD;
    assign bus.instr_done   = done;
    assign bus.halted       = state_q == S_HALT;
    assign bus.error        = state_q == S_ERROR;
    assign bus.retire_count = retire_q;
endmodule
